// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute over a shared
// memory port, decodes op/funct, counts retired instructions, flags illegal ops.
module multicycle_controller #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           op,
  input  logic [5:0]           funct,
  input  logic                 zero,
  input  logic                 memready,
  output logic                 iord,
  output logic                 memwrite,
  output logic                 irwrite,
  output logic                 pcen,
  output logic [1:0]           pcsrc,
  output logic                 alusrca,
  output logic [1:0]           alusrcb,
  output logic [2:0]           alucontrol,
  output logic                 regdst,
  output logic                 memtoreg,
  output logic                 regwrite,
  output logic                 illegal,
  output logic [3:0]           state,
  output logic [CNT_WIDTH-1:0] retired
);

  localparam logic [3:0] FETCH    = 4'd0;
  localparam logic [3:0] DECODE   = 4'd1;
  localparam logic [3:0] MEMADR   = 4'd2;
  localparam logic [3:0] MEMRD    = 4'd3;
  localparam logic [3:0] MEMWB    = 4'd4;
  localparam logic [3:0] MEMWR    = 4'd5;
  localparam logic [3:0] EXECUTE  = 4'd6;
  localparam logic [3:0] ALUWB    = 4'd7;
  localparam logic [3:0] BRANCH   = 4'd8;
  localparam logic [3:0] ADDIEXEC = 4'd9;
  localparam logic [3:0] ADDIWB   = 4'd10;
  localparam logic [3:0] JUMP     = 4'd11;

  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_RTYP = 6'b000000;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  logic [3:0]           r_state;
  logic [CNT_WIDTH-1:0] r_retired;
  logic [3:0]           w_next;
  logic                 w_funct_ok;
  logic                 w_illegal;
  logic                 w_retire;
  logic                 w_memwrite, w_irwrite, w_pcen, w_regwrite;

  always_comb begin
    w_funct_ok = 1'b0;
    case (funct)
      6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: w_funct_ok = 1'b1;
      default: w_funct_ok = 1'b0;
    endcase
  end

  always_comb begin
    w_next    = FETCH;
    w_illegal = 1'b0;
    case (r_state)
      FETCH:    w_next = memready ? DECODE : FETCH;
      DECODE: begin
        case (op)
          OP_LW, OP_SW: w_next = MEMADR;
          OP_RTYP: begin
            w_next    = w_funct_ok ? EXECUTE : FETCH;
            w_illegal = ~w_funct_ok;
          end
          OP_BEQ:  w_next = BRANCH;
          OP_ADDI: w_next = ADDIEXEC;
          OP_J:    w_next = JUMP;
          default: begin
            w_next    = FETCH;
            w_illegal = 1'b1;
          end
        endcase
      end
      MEMADR:   w_next = (op == OP_SW) ? MEMWR : MEMRD;
      MEMRD:    w_next = memready ? MEMWB : MEMRD;
      MEMWR:    w_next = memready ? FETCH : MEMWR;
      EXECUTE:  w_next = ALUWB;
      ADDIEXEC: w_next = ADDIWB;
      default:  w_next = FETCH;
    endcase
  end

  always_comb begin
    iord       = 1'b0;
    w_memwrite = 1'b0;
    w_irwrite  = 1'b0;
    w_pcen     = 1'b0;
    pcsrc      = 2'b00;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    alucontrol = 3'b010;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    w_regwrite = 1'b0;
    w_retire   = 1'b0;
    case (r_state)
      FETCH: begin
        alusrcb   = 2'b01;
        w_irwrite = memready;
        w_pcen    = memready;
      end
      DECODE:   alusrcb = 2'b11;
      MEMADR: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      MEMRD:    iord = 1'b1;
      MEMWB: begin
        memtoreg   = 1'b1;
        w_regwrite = 1'b1;
        w_retire   = 1'b1;
      end
      MEMWR: begin
        iord       = 1'b1;
        w_memwrite = 1'b1;
        w_retire   = memready;
      end
      EXECUTE: begin
        alusrca = 1'b1;
        case (funct)
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b010;
        endcase
      end
      ALUWB: begin
        regdst     = 1'b1;
        w_regwrite = 1'b1;
        w_retire   = 1'b1;
      end
      BRANCH: begin
        alusrca    = 1'b1;
        alucontrol = 3'b110;
        pcsrc      = 2'b01;
        w_pcen     = zero;
        w_retire   = 1'b1;
      end
      ADDIEXEC: begin
        alusrca = 1'b1;
        alusrcb = 2'b10;
      end
      ADDIWB: begin
        w_regwrite = 1'b1;
        w_retire   = 1'b1;
      end
      JUMP: begin
        pcsrc    = 2'b10;
        w_pcen   = 1'b1;
        w_retire = 1'b1;
      end
      default: ;
    endcase
  end

  // Strobes are gated by reset directly so an in-flight write dies in the same cycle.
  assign memwrite = w_memwrite & ~reset;
  assign irwrite  = w_irwrite  & ~reset;
  assign pcen     = w_pcen     & ~reset;
  assign regwrite = w_regwrite & ~reset;
  assign illegal  = (r_state == DECODE) & w_illegal & ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= FETCH;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_retired <= r_retired + 1'b1;
    end
  end

  assign state   = r_state;
  assign retired = r_retired;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: drives inputs after the falling edge,
// checks outputs 1 ns later against hand-computed values.
module tb_multicycle_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  op, funct;
  logic        zero, memready;

  logic        iord, memwrite, irwrite, pcen, alusrca, regdst, memtoreg, regwrite, illegal;
  logic [1:0]  pcsrc, alusrcb;
  logic [2:0]  alucontrol;
  logic [3:0]  state;
  logic [31:0] retired;

  logic        iord2, memwrite2, irwrite2, pcen2, alusrca2, regdst2, memtoreg2, regwrite2, illegal2;
  logic [1:0]  pcsrc2, alusrcb2;
  logic [2:0]  alucontrol2;
  logic [3:0]  state2;
  logic [1:0]  retired2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multicycle_controller #(.CNT_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .memready(memready),
    .iord(iord), .memwrite(memwrite), .irwrite(irwrite), .pcen(pcen), .pcsrc(pcsrc),
    .alusrca(alusrca), .alusrcb(alusrcb), .alucontrol(alucontrol), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .illegal(illegal), .state(state),
    .retired(retired)
  );

  multicycle_controller #(.CNT_WIDTH(2)) dut2 (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero), .memready(memready),
    .iord(iord2), .memwrite(memwrite2), .irwrite(irwrite2), .pcen(pcen2), .pcsrc(pcsrc2),
    .alusrca(alusrca2), .alusrcb(alusrcb2), .alucontrol(alucontrol2), .regdst(regdst2),
    .memtoreg(memtoreg2), .regwrite(regwrite2), .illegal(illegal2), .state(state2),
    .retired(retired2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; op = 6'b100011; funct = '0; zero = 1'b0; memready = 1'b1;

    nxt(); #1;
    check("rst_state", 32'(state), 0);
    check("rst_retired", retired, 0);
    check("rst_irwrite", 32'(irwrite), 0);
    check("rst_pcen", 32'(pcen), 0);

    // lw, memready high
    nxt(); reset = 1'b0; #1;
    check("lw_s0", 32'(state), 0);
    check("lw_fetch_irwrite", 32'(irwrite), 1);
    check("lw_fetch_pcen", 32'(pcen), 1);
    check("lw_fetch_alusrcb", 32'(alusrcb), 1);
    nxt(); #1;
    check("lw_s1", 32'(state), 1);
    check("lw_dec_alusrcb", 32'(alusrcb), 3);
    check("lw_dec_illegal", 32'(illegal), 0);
    nxt(); #1;
    check("lw_s2", 32'(state), 2);
    check("lw_adr_srca", 32'(alusrca), 1);
    check("lw_adr_srcb", 32'(alusrcb), 2);
    nxt(); #1;
    check("lw_s3", 32'(state), 3);
    check("lw_rd_iord", 32'(iord), 1);
    check("lw_rd_regwrite", 32'(regwrite), 0);
    nxt(); #1;
    check("lw_s4", 32'(state), 4);
    check("lw_wb_regwrite", 32'(regwrite), 1);
    check("lw_wb_memtoreg", 32'(memtoreg), 1);
    check("lw_wb_retired", retired, 0);
    nxt(); op = 6'b101011; #1;
    check("lw_done_state", 32'(state), 0);
    check("lw_done_retired", retired, 1);

    // sw with 3 wait cycles in MEMWR
    nxt(); nxt(); nxt();
    memready = 1'b0; #1;
    check("sw_s5", 32'(state), 5);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        nxt();
        memready = (i == 3);
        #1;
      end
      check("sw_memwrite", 32'(memwrite), 1);
      check("sw_iord", 32'(iord), 1);
      check("sw_state_hold", 32'(state), 5);
      check("sw_retired_wait", retired, 1);
    end
    nxt(); op = 6'b000000; funct = 6'b101010; #1;
    check("sw_done_state", 32'(state), 0);
    check("sw_done_retired", retired, 2);

    // R-type slt
    nxt(); #1;
    check("slt_illegal", 32'(illegal), 0);
    nxt(); #1;
    check("slt_s6", 32'(state), 6);
    check("slt_aluctl", 32'(alucontrol), 3'b111);
    check("slt_srcb", 32'(alusrcb), 0);
    nxt(); #1;
    check("slt_s7", 32'(state), 7);
    check("slt_regdst", 32'(regdst), 1);
    check("slt_regwrite", 32'(regwrite), 1);
    nxt(); funct = 6'b000000; #1;
    check("slt_retired", retired, 3);

    // R-type with bad funct
    nxt(); #1;
    check("badf_illegal", 32'(illegal), 1);
    nxt(); op = 6'b111111; #1;
    check("badf_state", 32'(state), 0);
    check("badf_illegal_off", 32'(illegal), 0);
    check("badf_retired", retired, 3);

    // unsupported op
    nxt(); #1;
    check("badop_illegal", 32'(illegal), 1);
    nxt(); op = 6'b000100; zero = 1'b1; #1;
    check("badop_state", 32'(state), 0);
    check("badop_retired", retired, 3);

    // beq taken then not taken
    nxt(); nxt(); #1;
    check("beq1_s8", 32'(state), 8);
    check("beq1_pcen", 32'(pcen), 1);
    check("beq1_pcsrc", 32'(pcsrc), 1);
    check("beq1_aluctl", 32'(alucontrol), 3'b110);
    nxt(); zero = 1'b0; #1;
    check("beq1_retired", retired, 4);
    nxt(); nxt(); #1;
    check("beq0_s8", 32'(state), 8);
    check("beq0_pcen", 32'(pcen), 0);
    nxt(); op = 6'b000010; #1;
    check("beq0_retired", retired, 5);

    // jump
    nxt(); nxt(); #1;
    check("j_s11", 32'(state), 11);
    check("j_pcen", 32'(pcen), 1);
    check("j_pcsrc", 32'(pcsrc), 2);
    nxt(); memready = 1'b0; op = 6'b101011; #1;
    check("j_retired", retired, 6);
    check("wrap_pre_retired2", 32'(retired2), 2);

    // FETCH stalled two cycles
    check("stall0_irwrite", 32'(irwrite), 0);
    check("stall0_pcen", 32'(pcen), 0);
    nxt(); #1;
    check("stall1_state", 32'(state), 0);
    check("stall1_irwrite", 32'(irwrite), 0);
    nxt(); memready = 1'b1; #1;
    check("stall2_irwrite", 32'(irwrite), 1);
    check("stall2_pcen", 32'(pcen), 1);

    // reset during MEMWR
    nxt(); nxt(); nxt(); memready = 1'b0; #1;
    check("rstmw_s5", 32'(state), 5);
    check("rstmw_memwrite_pre", 32'(memwrite), 1);
    nxt(); reset = 1'b1; #1;
    check("rstmw_memwrite", 32'(memwrite), 0);
    check("rstmw_state", 32'(state), 0);
    check("rstmw_retired", retired, 0);

    // four jumps: narrow counter wraps
    nxt(); reset = 1'b0; memready = 1'b1; op = 6'b000010; #1;
    for (int i = 0; i < 4; i++) begin
      nxt(); nxt(); nxt();
    end
    #1;
    check("wrap_retired32", retired, 4);
    check("wrap_retired2", 32'(retired2), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
